// File: rtl/lzw_pkg.sv
// rtl/lzw_pkg.sv - shared constants, FSM state type and hash for the LZW stream encoder
//
// Purpose : common definitions imported by the encoder top.
//           CLEAR_CODE / FIRST_CODE : reserved code values of the code space
//           lzw_state_t             : encoder FSM states
//           lzw_hash()              : dictionary table index of a (prefix, char) pair
// Ports   : none (package)

package lzw_pkg;

   localparam int CLEAR_CODE = 256;
   localparam int FIRST_CODE = 257;

   typedef enum logic [2:0] {
      CLEAR,
      IDLE,
      FETCH,
      PROBE,
      CMP,
      EMIT,
      CLREMIT,
      FLUSH
   } lzw_state_t;

   // hash(p,c) = (p ^ (c << (aw-8))) mod 2^aw. Valid for 8 <= aw <= 16.
   // The character lands in the top byte of the index so that literal
   // prefixes (which occupy the low byte) spread over the whole table.
   function automatic logic [15:0] lzw_hash(input logic [15:0] p,
                                            input logic [7:0]  c,
                                            input int          aw);
      logic [31:0] h;
      h = {16'd0, p} ^ ({24'd0, c} << (aw - 8));
      h = h & ((32'd1 << aw) - 32'd1);
      return h[15:0];
   endfunction

endpackage

// File: rtl/lzw_stream_encoder_if.sv
// rtl/lzw_stream_encoder_if.sv - byte-in / code-out handshake bundle of the LZW encoder
//
// Purpose : groups the input byte stream, output code stream and status.
//   in_valid_i / in_data_i[8] / in_last_i / in_ready_o : byte stream into the encoder
//   out_valid_o / out_code_o[CODE_W] / out_last_o / out_ready_i : code stream out
//   busy_o : encoder is not in IDLE
// Modports: slave = encoder side, master = byte source / code sink side.

interface lzw_stream_encoder_if #(
   parameter int CODE_W = 12
) ();

   logic              in_valid_i;
   logic [7:0]        in_data_i;
   logic              in_last_i;
   logic              in_ready_o;
   logic              out_valid_o;
   logic [CODE_W-1:0] out_code_o;
   logic              out_last_o;
   logic              out_ready_i;
   logic              busy_o;

   modport slave (
      input  in_valid_i, in_data_i, in_last_i, out_ready_i,
      output in_ready_o, out_valid_o, out_code_o, out_last_o, busy_o
   );

   modport master (
      output in_valid_i, in_data_i, in_last_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_code_o, out_last_o, busy_o
   );

endinterface

// File: rtl/lzw_hash_table.sv
// rtl/lzw_hash_table.sv - dictionary storage: one write port, one synchronous read port
//
// Purpose : 2^HASH_AW entries of type entry_t. Read data appears one cycle
//           after the address; a write to the address being read in the same
//           cycle is forwarded (write-first). No reset: the encoder
//           invalidates every entry by sweeping valid=0 writes.
// Ports   : clk              clock
//           i_we/i_waddr/i_wdata  write port
//           i_raddr/o_rdata       read port (1-cycle latency)

module lzw_hash_table #(
   parameter int  HASH_AW = 13,
   parameter type entry_t = logic [32:0]
) (
   input  logic               clk,
   input  logic               i_we,
   input  logic [HASH_AW-1:0] i_waddr,
   input  entry_t             i_wdata,
   input  logic [HASH_AW-1:0] i_raddr,
   output entry_t             o_rdata
);

   entry_t r_mem [2**HASH_AW];
   entry_t r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_we && (i_waddr == i_raddr)) begin
         r_rdata <= i_wdata;
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/lzw_stream_encoder.sv
// rtl/lzw_stream_encoder.sv - streaming LZW compressor with hashed, linear-probed dictionary
//
// Purpose : bytes in over valid/ready, fixed CODE_W-bit codes out over
//           valid/ready. Codes 0..255 are literals, 256 is CLEAR, 257 up are
//           dictionary entries. When the insertion of code 2^CODE_W-1 fills
//           the dictionary a 256 is emitted and the table is wiped. Every frame
//           starts from an empty dictionary.
// Ports   : clk       clock, all state on rising edge
//           reset_ni  asynchronous active-low reset
//           bus       lzw_stream_encoder_if.slave (byte stream, code stream, busy_o)

module lzw_stream_encoder
   import lzw_pkg::*;
#(
   parameter int CODE_W  = 12,
   parameter int HASH_AW = 13
) (
   input logic                 clk,
   input logic                 reset_ni,
   lzw_stream_encoder_if.slave bus
);

   // The probe loop only terminates if the table never exceeds half full.
   if ((2**HASH_AW) < 2 * ((2**CODE_W) - FIRST_CODE) || HASH_AW < 8 || HASH_AW > 16 ||
       CODE_W < 9 || CODE_W > 16) begin : g_bad_cfg
      $error("lzw_stream_encoder: HASH_AW too small for CODE_W or parameter out of range");
   end

   typedef struct packed {
      logic              valid;
      logic [CODE_W-1:0] prefix;
      logic [7:0]        chr;
      logic [CODE_W-1:0] code;
   } entry_t;

   localparam logic [CODE_W-1:0]  MAX_CODE = '1;
   localparam logic [CODE_W-1:0]  CLR_CODE = CODE_W'(CLEAR_CODE);
   localparam logic [CODE_W-1:0]  NEW_CODE = CODE_W'(FIRST_CODE);
   localparam logic [HASH_AW-1:0] ADDR_MAX = '1;

   lzw_state_t         r_state;
   logic [HASH_AW-1:0] r_addr;       // sweep pointer
   logic [HASH_AW-1:0] r_idx;        // probe index
   logic [CODE_W-1:0]  r_prefix;
   logic [7:0]         r_char;
   logic               r_last;       // r_char was the final byte of the frame
   logic [CODE_W-1:0]  r_next_code;
   logic               r_full;       // last insertion used the top code
   logic               r_mid;        // sweep happens inside a frame (after CLREMIT)
   logic               r_out_valid;
   logic [CODE_W-1:0]  r_out_code;
   logic               r_out_last;
   logic               r_in_ready;
   logic               r_busy;

   logic               w_we;
   logic [HASH_AW-1:0] w_waddr;
   entry_t             w_wdata;
   entry_t             w_rd;
   logic               w_match;
   logic [HASH_AW-1:0] w_hash;

   lzw_hash_table #(
      .HASH_AW (HASH_AW),
      .entry_t (entry_t)
   ) u_table (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (r_idx),
      .o_rdata (w_rd)
   );

   assign w_hash  = HASH_AW'(lzw_hash(16'(r_prefix), bus.in_data_i, HASH_AW));
   assign w_match = w_rd.valid && (w_rd.prefix == r_prefix) && (w_rd.chr == r_char);

   // Table writes: invalidation sweep, or insertion of a new pair on a miss.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_idx;
      w_wdata = '0;
      if (r_state == CLEAR) begin
         w_we    = 1'b1;
         w_waddr = r_addr;
      end else if (r_state == CMP && !w_rd.valid) begin
         w_we           = 1'b1;
         w_wdata.valid  = 1'b1;
         w_wdata.prefix = r_prefix;
         w_wdata.chr    = r_char;
         w_wdata.code   = r_next_code;
      end
   end

   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state     <= CLEAR;
         r_addr      <= '0;
         r_idx       <= '0;
         r_prefix    <= '0;
         r_char      <= '0;
         r_last      <= 1'b0;
         r_next_code <= NEW_CODE;
         r_full      <= 1'b0;
         r_mid       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_code  <= '0;
         r_out_last  <= 1'b0;
         r_in_ready  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            CLEAR: begin
               r_addr <= r_addr + HASH_AW'(1);
               r_busy <= 1'b1;
               if (r_addr == ADDR_MAX) begin
                  r_next_code <= NEW_CODE;
                  r_mid       <= 1'b0;
                  if (!r_mid) begin
                     r_state    <= IDLE;
                     r_in_ready <= 1'b1;
                     r_busy     <= 1'b0;
                  end else if (r_last) begin
                     r_state     <= FLUSH;
                     r_out_valid <= 1'b1;
                     r_out_code  <= r_prefix;
                     r_out_last  <= 1'b1;
                  end else begin
                     r_state    <= FETCH;
                     r_in_ready <= 1'b1;
                  end
               end
            end

            IDLE: begin
               if (bus.in_valid_i) begin
                  r_prefix <= CODE_W'(bus.in_data_i);
                  r_busy   <= 1'b1;
                  if (bus.in_last_i) begin
                     r_state     <= FLUSH;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_out_code  <= CODE_W'(bus.in_data_i);
                     r_out_last  <= 1'b1;
                  end else begin
                     r_state <= FETCH;
                  end
               end
            end

            FETCH: begin
               if (bus.in_valid_i) begin
                  r_char     <= bus.in_data_i;
                  r_last     <= bus.in_last_i;
                  r_idx      <= w_hash;
                  r_state    <= PROBE;
                  r_in_ready <= 1'b0;
               end
            end

            PROBE: begin
               r_state <= CMP;
            end

            CMP: begin
               if (w_rd.valid) begin
                  if (w_match) begin
                     r_prefix <= w_rd.code;
                     if (r_last) begin
                        r_state     <= FLUSH;
                        r_out_valid <= 1'b1;
                        r_out_code  <= w_rd.code;
                        r_out_last  <= 1'b1;
                     end else begin
                        r_state    <= FETCH;
                        r_in_ready <= 1'b1;
                     end
                  end else begin
                     // collision: linear probe, index wraps with its width
                     r_idx   <= r_idx + HASH_AW'(1);
                     r_state <= PROBE;
                  end
               end else begin
                  r_next_code <= r_next_code + CODE_W'(1);
                  r_full      <= (r_next_code == MAX_CODE);
                  r_out_valid <= 1'b1;
                  r_out_code  <= r_prefix;
                  r_out_last  <= 1'b0;
                  r_prefix    <= CODE_W'(r_char);
                  r_state     <= EMIT;
               end
            end

            EMIT: begin
               if (bus.out_ready_i) begin
                  if (r_full) begin
                     // out_valid stays high: the CLEAR code follows immediately
                     r_full     <= 1'b0;
                     r_out_code <= CLR_CODE;
                     r_out_last <= 1'b0;
                     r_state    <= CLREMIT;
                  end else if (r_last) begin
                     r_out_code <= r_prefix;
                     r_out_last <= 1'b1;
                     r_state    <= FLUSH;
                  end else begin
                     r_out_valid <= 1'b0;
                     r_in_ready  <= 1'b1;
                     r_state     <= FETCH;
                  end
               end
            end

            CLREMIT: begin
               if (bus.out_ready_i) begin
                  r_out_valid <= 1'b0;
                  r_next_code <= NEW_CODE;
                  r_mid       <= 1'b1;
                  r_state     <= CLEAR;
               end
            end

            FLUSH: begin
               if (bus.out_ready_i) begin
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
                  r_mid       <= 1'b0;
                  r_state     <= CLEAR;
               end
            end

            default: begin
               r_state <= CLEAR;
            end
         endcase
      end
   end

   assign bus.in_ready_o  = r_in_ready;
   assign bus.out_valid_o = r_out_valid;
   assign bus.out_code_o  = r_out_code;
   assign bus.out_last_o  = r_out_last;
   assign bus.busy_o      = r_busy;

endmodule

// File: tb/tb_lzw_stream_encoder.sv
// tb/tb_lzw_stream_encoder.sv - scoreboard bench for the LZW stream encoder

module tb_lzw_stream_encoder;

   localparam int CODE_W  = 9;
   localparam int HASH_AW = 9;
   localparam int SWEEP   = 1 << HASH_AW;
   localparam int LIMIT   = 20000;

   typedef struct {
      int code;
      bit last;
   } exp_t;

   typedef logic [7:0] bq_t [$];

   logic clk = 1'b0;
   logic reset_ni = 1'b0;

   lzw_stream_encoder_if #(.CODE_W(CODE_W)) bus ();

   lzw_stream_encoder #(
      .CODE_W  (CODE_W),
      .HASH_AW (HASH_AW)
   ) dut (
      .clk      (clk),
      .reset_ni (reset_ni),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q [$];
   int   rx_q [$];
   int   ready_mode = 0;   // 0: always ready, 1: ready 30% of cycles, 2: never ready
   int   dec_pre [1 << CODE_W];
   int   dec_chr [1 << CODE_W];

   function automatic void check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endfunction

   function automatic void push_exp(input int code, input bit last);
      exp_t e;
      e.code = code;
      e.last = last;
      exp_q.push_back(e);
   endfunction

   // Reference LZW encoder on an associative-array dictionary.
   function automatic void model_encode(input bq_t d);
      int dict [int];
      int nxt;
      int p;
      int c;
      int key;
      nxt = 257;
      p   = int'(d[0]);
      for (int i = 1; i < d.size(); i++) begin
         c   = int'(d[i]);
         key = p * 256 + c;
         if (dict.exists(key)) begin
            p = dict[key];
         end else begin
            dict[key] = nxt;
            push_exp(p, 1'b0);
            if (nxt == (1 << CODE_W) - 1) begin
               push_exp(256, 1'b0);
               dict.delete();
               nxt = 257;
            end else begin
               nxt++;
            end
            p = c;
         end
      end
      push_exp(p, 1'b1);
   endfunction

   function automatic bq_t expand(input int k);
      bq_t s;
      int  x;
      int  guard;
      x     = k;
      guard = 0;
      while (x >= 257 && guard < 1024) begin
         s.push_front(8'(dec_chr[x]));
         x = dec_pre[x];
         guard++;
      end
      s.push_front(8'(x));
      return s;
   endfunction

   // Reference decoder over the received codes; must give back the input.
   function automatic void decode_check(input bq_t d);
      bq_t outb;
      bq_t seq;
      int  nxt;
      int  prev;
      int  bad;
      nxt  = 257;
      prev = -1;
      bad  = -1;
      foreach (rx_q[j]) begin
         if (rx_q[j] == 256) begin
            prev = -1;
            nxt  = 257;
         end else begin
            seq.delete();
            if (rx_q[j] < 256 || rx_q[j] < nxt) begin
               seq = expand(rx_q[j]);
            end else if (prev != -1 && rx_q[j] == nxt) begin
               seq = expand(prev);
               seq.push_back(seq[0]);
            end
            if (seq.size() == 0) begin
               if (bad < 0) bad = j;
            end else begin
               if (prev != -1 && nxt < (1 << CODE_W)) begin
                  dec_pre[nxt] = prev;
                  dec_chr[nxt] = int'(seq[0]);
                  nxt++;
               end
               foreach (seq[m]) outb.push_back(seq[m]);
               prev = rx_q[j];
            end
         end
      end
      check("decode_len", outb.size(), d.size());
      for (int i = 0; i < outb.size() && i < d.size(); i++) begin
         if (outb[i] != d[i] && bad < 0) bad = i;
      end
      check("decode_first_bad_index", bad, -1);
   endfunction

   // Scoreboard monitor: compares every accepted code, and checks that a
   // stalled code holds still until it is taken.
   initial begin
      exp_t e;
      bit   prev_stall;
      int   prev_code;
      bit   prev_last;
      prev_stall = 1'b0;
      prev_code  = 0;
      prev_last  = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_ni) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_valid", int'(bus.out_valid_o), 1);
               check("stall_code", int'(bus.out_code_o), prev_code);
               check("stall_last", int'(bus.out_last_o), int'(prev_last));
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_code", int'(bus.out_code_o), -1);
               end else begin
                  e = exp_q.pop_front();
                  check("code", int'(bus.out_code_o), e.code);
                  check("last", int'(bus.out_last_o), int'(e.last));
               end
               rx_q.push_back(int'(bus.out_code_o));
            end
            prev_stall = bus.out_valid_o && !bus.out_ready_i;
            prev_code  = int'(bus.out_code_o);
            prev_last  = bus.out_last_o;
         end
      end
   end

   // Downstream ready generator.
   initial begin
      bus.out_ready_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.out_ready_i = 1'b1;
            1:       bus.out_ready_i = ($urandom_range(0, 9) < 3);
            default: bus.out_ready_i = 1'b0;
         endcase
      end
   end

   // Called at posedge+1; returns at posedge+1 after the byte was accepted.
   task automatic send_byte(input logic [7:0] b, input bit l);
      int n;
      n = 0;
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = b;
      bus.in_last_i  = l;
      while (!bus.in_ready_o && n < LIMIT) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= LIMIT) check("in_handshake_timeout", n, 0);
      @(posedge clk);
      #1;
      bus.in_valid_i = 1'b0;
      bus.in_last_i  = 1'b0;
   endtask

   task automatic send_frame(input bq_t q);
      for (int i = 0; i < q.size(); i++) begin
         send_byte(q[i], i == q.size() - 1);
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.busy_o || !bus.in_ready_o) && n < LIMIT) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({name, "_done"}, int'(n < LIMIT), 1);
   endtask

   task automatic measure_sweep(input string name);
      int n;
      n = 0;
      while (!bus.in_ready_o && n < 4 * SWEEP) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({name, "_cycles"}, n, SWEEP);
      check({name, "_busy"}, int'(bus.busy_o), 0);
   endtask

   task automatic run_aaaa(input string name);
      bq_t q;
      for (int i = 0; i < 4; i++) q.push_back(8'd65);
      push_exp(65, 1'b0);
      push_exp(257, 1'b0);
      push_exp(65, 1'b1);
      send_frame(q);
      wait_idle(name);
   endtask

   task automatic run_tobe(input string name);
      string s;
      bq_t   q;
      int    codes [16];
      s     = "TOBEORNOTTOBEORTOBEORNOT";
      codes = '{84, 79, 66, 69, 79, 82, 78, 79, 84, 257, 259, 261, 266, 260, 262, 264};
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      for (int i = 0; i < 16; i++) push_exp(codes[i], i == 15);
      send_frame(q);
      wait_idle(name);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t q;
      int  n;
      bus.in_valid_i = 1'b0;
      bus.in_data_i  = 8'd0;
      bus.in_last_i  = 1'b0;
      reset_ni       = 1'b0;
      #3;
      check("rst_out_valid", int'(bus.out_valid_o), 0);
      check("rst_out_code", int'(bus.out_code_o), 0);
      check("rst_out_last", int'(bus.out_last_o), 0);
      check("rst_in_ready", int'(bus.in_ready_o), 0);
      check("rst_busy", int'(bus.busy_o), 0);
      #20;
      @(posedge clk);
      #1;
      reset_ni = 1'b1;
      measure_sweep("init_sweep");

      ready_mode = 0;
      run_aaaa("aaaa");
      run_tobe("tobe");

      ready_mode = 1;
      run_tobe("tobe_stall");
      ready_mode = 0;

      push_exp(8'h5A, 1'b1);
      send_byte(8'h5A, 1'b1);
      wait_idle("single");

      q.delete();
      for (int i = 0; i < 600; i++) q.push_back(8'(i));
      model_encode(q);
      check("inc_clear_position", exp_q[255].code, 256);
      rx_q.delete();
      send_frame(q);
      wait_idle("inc600");
      decode_check(q);

      ready_mode = 2;
      send_byte(8'd65, 1'b0);
      send_byte(8'd66, 1'b0);
      n = 0;
      while (!bus.out_valid_o && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("emit_before_reset", int'(bus.out_valid_o), 1);
      #2;
      reset_ni = 1'b0;
      #1;
      check("reset_drops_valid", int'(bus.out_valid_o), 0);
      check("reset_in_ready", int'(bus.in_ready_o), 0);
      check("reset_no_pending_expect", exp_q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
      ready_mode = 0;
      reset_ni   = 1'b1;
      measure_sweep("reset_sweep");
      run_aaaa("aaaa_after_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
